// File: rtl/seq_store_unit_if.sv
// Bus bundle for seq_store_unit: store request metadata, sequential beat input,
// AXI-style write burst toward memory, and per-request completion report.
interface seq_store_unit_if #(
    parameter int NrLanes   = 4,
    parameter int DLEN      = 64,
    parameter int AddrBits  = 64,
    parameter int ReqIdBits = 4,
    parameter int LenBits   = 8
) ();
    localparam int BusBytes = NrLanes * DLEN / 8;

    logic                   meta_valid_i;
    logic                   meta_ready_o;
    logic [AddrBits-1:0]    meta_addr_i;
    logic [LenBits-1:0]     meta_nbeats_i;
    logic [ReqIdBits-1:0]   meta_reqid_i;

    logic                   in_valid_i;
    logic                   in_ready_o;
    logic [BusBytes*8-1:0]  in_nb_i;
    logic [BusBytes*2-1:0]  in_en_i;

    logic                   aw_valid_o;
    logic                   aw_ready_i;
    logic [AddrBits-1:0]    aw_addr_o;
    logic [LenBits-1:0]     aw_len_o;

    logic                   w_valid_o;
    logic                   w_ready_i;
    logic [BusBytes*8-1:0]  w_data_o;
    logic [BusBytes-1:0]    w_strb_o;
    logic                   w_last_o;

    logic                   b_valid_i;
    logic                   b_ready_o;
    logic                   b_err_i;

    logic                   done_o;
    logic [ReqIdBits-1:0]   done_reqid_o;
    logic                   done_err_o;

    // The store unit itself sits on the slave side of this bundle.
    modport slave (
        input  meta_valid_i, meta_addr_i, meta_nbeats_i, meta_reqid_i,
        output meta_ready_o,
        input  in_valid_i, in_nb_i, in_en_i,
        output in_ready_o,
        output aw_valid_o, aw_addr_o, aw_len_o,
        input  aw_ready_i,
        output w_valid_o, w_data_o, w_strb_o, w_last_o,
        input  w_ready_i,
        input  b_valid_i, b_err_i,
        output b_ready_o,
        output done_o, done_reqid_o, done_err_o
    );

    modport master (
        output meta_valid_i, meta_addr_i, meta_nbeats_i, meta_reqid_i,
        input  meta_ready_o,
        output in_valid_i, in_nb_i, in_en_i,
        input  in_ready_o,
        input  aw_valid_o, aw_addr_o, aw_len_o,
        output aw_ready_i,
        input  w_valid_o, w_data_o, w_strb_o, w_last_o,
        output w_ready_i,
        output b_valid_i, b_err_i,
        input  b_ready_o,
        input  done_o, done_reqid_o, done_err_o
    );
endinterface

// File: rtl/seq_store_unit.sv
// Realigns sequential-order store beats to the request's byte start address and
// issues one write burst per request, with a trailing flush beat for misaligned starts.
module seq_store_unit #(
    parameter int NrLanes   = 4,
    parameter int DLEN      = 64,
    parameter int AddrBits  = 64,
    parameter int ReqIdBits = 4,
    parameter int LenBits   = 8
) (
    input logic         clk_i,
    input logic         rst_i,
    seq_store_unit_if.slave bus
);
    localparam int BusBytes = NrLanes * DLEN / 8;
    localparam int BusBits  = BusBytes * 8;
    localparam int OffBits  = $clog2(BusBytes);

    typedef enum logic [2:0] {IDLE, ADDR, DATA, FLUSH, RESP} state_e;

    state_e                     state_q, state_d;
    logic [AddrBits-1:OffBits]  addr_q;
    logic [ReqIdBits-1:0]       reqid_q;
    logic [LenBits-1:0]         nbeats_q;
    logic [LenBits-1:0]         beat_cnt_q;
    logic [OffBits-1:0]         off_q;
    logic [BusBits-1:0]         prev_data_q;
    logic [BusBytes-1:0]        prev_strb_q;
    logic                       mismatch_q;

    logic [BusBytes-1:0]        in_strb;
    logic                       in_mismatch;
    logic [BusBits-1:0]         cur_data;
    logic [BusBytes-1:0]        cur_strb;
    logic [OffBits:0]           shift_bytes;
    logic [2*BusBits-1:0]       cat_data;
    logic [2*BusBytes-1:0]      cat_strb;
    logic [BusBits-1:0]         al_data;
    logic [BusBytes-1:0]        al_strb;

    logic                       off_zero;
    logic                       is_last;
    logic                       meta_hs;
    logic                       data_hs;

    logic                       meta_ready;
    logic                       in_ready;
    logic                       aw_valid;
    logic [AddrBits-1:0]        aw_addr;
    logic [LenBits-1:0]         aw_len;
    logic                       w_valid;
    logic [BusBits-1:0]         w_data;
    logic [BusBytes-1:0]        w_strb;
    logic                       w_last;
    logic                       b_ready;
    logic                       done;
    logic [ReqIdBits-1:0]       done_reqid;
    logic                       done_err;

    // A byte is written only when both of its nibbles are enabled; a split pair is an error.
    always_comb begin
        in_strb     = '0;
        in_mismatch = 1'b0;
        for (int b = 0; b < BusBytes; b++) begin
            in_strb[b]  = bus.in_en_i[2*b] & bus.in_en_i[2*b+1];
            in_mismatch = in_mismatch | (bus.in_en_i[2*b] ^ bus.in_en_i[2*b+1]);
        end
    end

    // Concatenate current beat above the previous one and pick the window starting
    // BusBytes-off bytes up; the low off bytes are then the carried residue.
    always_comb begin
        cur_data    = (state_q == DATA) ? bus.in_nb_i : '0;
        cur_strb    = (state_q == DATA) ? in_strb : '0;
        shift_bytes = (OffBits+1)'(BusBytes) - {1'b0, off_q};
        cat_data    = {cur_data, prev_data_q} >> {shift_bytes, 3'b000};
        cat_strb    = {cur_strb, prev_strb_q} >> shift_bytes;
        al_data     = cat_data[BusBits-1:0];
        al_strb     = cat_strb[BusBytes-1:0];
    end

    assign off_zero = (off_q == '0);
    assign is_last  = (beat_cnt_q == nbeats_q - LenBits'(1));
    assign meta_hs  = (state_q == IDLE) && bus.meta_valid_i;
    assign data_hs  = (state_q == DATA) && bus.in_valid_i && bus.w_ready_i;

    always_comb begin
        state_d    = state_q;
        meta_ready = 1'b0;
        in_ready   = 1'b0;
        aw_valid   = 1'b0;
        aw_addr    = '0;
        aw_len     = '0;
        w_valid    = 1'b0;
        w_data     = '0;
        w_strb     = '0;
        w_last     = 1'b0;
        b_ready    = 1'b0;
        done       = 1'b0;
        done_reqid = '0;
        done_err   = 1'b0;
        case (state_q)
            IDLE: begin
                meta_ready = ~rst_i;
                if (meta_hs) state_d = ADDR;
            end
            ADDR: begin
                aw_valid = 1'b1;
                aw_addr  = {addr_q, {OffBits{1'b0}}};
                aw_len   = nbeats_q - LenBits'(off_zero);
                if (bus.aw_ready_i) state_d = DATA;
            end
            DATA: begin
                w_valid  = bus.in_valid_i;
                in_ready = bus.w_ready_i;
                w_data   = al_data;
                w_strb   = al_strb;
                w_last   = bus.in_valid_i && is_last && off_zero;
                if (data_hs && is_last) state_d = off_zero ? RESP : FLUSH;
            end
            FLUSH: begin
                w_valid = 1'b1;
                w_last  = 1'b1;
                w_data  = al_data;
                w_strb  = al_strb;
                if (bus.w_ready_i) state_d = RESP;
            end
            RESP: begin
                b_ready = 1'b1;
                if (bus.b_valid_i) begin
                    done       = 1'b1;
                    done_reqid = reqid_q;
                    done_err   = mismatch_q | bus.b_err_i;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Residue is cleared at request start so the first beat's low bytes carry no strobes.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            reqid_q     <= '0;
            nbeats_q    <= '0;
            beat_cnt_q  <= '0;
            off_q       <= '0;
            prev_data_q <= '0;
            prev_strb_q <= '0;
            mismatch_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (meta_hs) begin
                addr_q      <= bus.meta_addr_i[AddrBits-1:OffBits];
                off_q       <= bus.meta_addr_i[OffBits-1:0];
                reqid_q     <= bus.meta_reqid_i;
                nbeats_q    <= bus.meta_nbeats_i;
                beat_cnt_q  <= '0;
                prev_data_q <= '0;
                prev_strb_q <= '0;
                mismatch_q  <= 1'b0;
            end
            if (data_hs) begin
                prev_data_q <= bus.in_nb_i;
                prev_strb_q <= in_strb;
                beat_cnt_q  <= beat_cnt_q + LenBits'(1);
                mismatch_q  <= mismatch_q | in_mismatch;
            end
        end
    end

    assign bus.meta_ready_o = meta_ready;
    assign bus.in_ready_o   = in_ready;
    assign bus.aw_valid_o   = aw_valid;
    assign bus.aw_addr_o    = aw_addr;
    assign bus.aw_len_o     = aw_len;
    assign bus.w_valid_o    = w_valid;
    assign bus.w_data_o     = w_data;
    assign bus.w_strb_o     = w_strb;
    assign bus.w_last_o     = w_last;
    assign bus.b_ready_o    = b_ready;
    assign bus.done_o       = done;
    assign bus.done_reqid_o = done_reqid;
    assign bus.done_err_o   = done_err;

endmodule

// File: tb/tb_seq_store_unit.sv
// Directed bench for seq_store_unit: expected output beats come from a byte-level
// realignment model, queued at stimulus time and popped on each write handshake.
module tb_seq_store_unit;
    localparam int BusBytes = 32;
    localparam int BusBits  = 256;

    typedef struct {
        logic [BusBits-1:0]  data;
        logic [BusBytes-1:0] strb;
        logic                last;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   compCount = 0;
    int   failCount = 0;

    beat_t              expQ[$];
    logic [BusBits-1:0] inData [8];
    logic [63:0]        inEn [8];

    always #5 clk = ~clk;

    seq_store_unit_if bus ();

    seq_store_unit dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    task automatic checkOutput(input string tag, input logic [BusBits-1:0] obs, input logic [BusBits-1:0] exp);
        compCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // One full request: model the expected burst, then drive meta/aw/w/b in order.
    task automatic applyStimulus(input logic [63:0] addr, input int nbeats, input logic [3:0] reqid,
                                 input logic berr, input int stallBeat, input int stallCycles,
                                 input int misBeat, input int abortAfter);
        int                 off;
        int                 outbeats;
        int                 src;
        int                 sb;
        logic               have;
        logic               expErr;
        beat_t              e;
        logic [BusBits-1:0] mask;

        off      = int'(addr[4:0]);
        outbeats = nbeats + ((off != 0) ? 1 : 0);
        expErr   = berr | (misBeat >= 0 && misBeat < nbeats);

        for (int i = 0; i < nbeats; i++) begin
            inData[i] = {$urandom(), $urandom(), $urandom(), $urandom(),
                         $urandom(), $urandom(), $urandom(), $urandom()};
            inEn[i] = '1;
            if (i == misBeat) inEn[i][1] = 1'b0;
        end

        for (int j = 0; j < outbeats; j++) begin
            e.data = '0;
            e.strb = '0;
            for (int k = 0; k < BusBytes; k++) begin
                have = 1'b0;
                src  = 0;
                sb   = 0;
                if (k >= off) begin
                    if (j < nbeats) begin src = j; sb = k - off; have = 1'b1; end
                end else if (j >= 1) begin
                    src = j - 1; sb = BusBytes - off + k; have = 1'b1;
                end
                if (have) begin
                    e.data[8*k +: 8] = inData[src][8*sb +: 8];
                    e.strb[k]        = inEn[src][2*sb] & inEn[src][2*sb+1];
                end
            end
            e.last = (j == outbeats - 1);
            expQ.push_back(e);
        end

        nextCycle();
        bus.meta_valid_i  = 1'b1;
        bus.meta_addr_i   = addr;
        bus.meta_nbeats_i = 8'(nbeats);
        bus.meta_reqid_i  = reqid;
        @(negedge clk);
        checkOutput("meta_ready", bus.meta_ready_o, 1'b1);
        nextCycle();
        bus.meta_valid_i = 1'b0;
        @(negedge clk);
        checkOutput("aw_valid", bus.aw_valid_o, 1'b1);
        checkOutput("aw_addr", bus.aw_addr_o, addr & ~64'h1F);
        checkOutput("aw_len", bus.aw_len_o, outbeats - 1);
        checkOutput("idle_in_ready", bus.in_ready_o, 1'b0);
        nextCycle();
        @(negedge clk);
        checkOutput("aw_hold", bus.aw_valid_o, 1'b1);
        nextCycle();
        bus.aw_ready_i = 1'b1;
        nextCycle();
        bus.aw_ready_i = 1'b0;

        for (int j = 0; j < outbeats; j++) begin
            if (j < nbeats) begin
                bus.in_valid_i = 1'b1;
                bus.in_nb_i    = inData[j];
                bus.in_en_i    = inEn[j];
            end else begin
                bus.in_valid_i = 1'b0;
                bus.in_nb_i    = '0;
                bus.in_en_i    = '0;
            end

            if (abortAfter > 0 && j == abortAfter) begin
                bus.w_ready_i = 1'b1;
                #1;
                checkOutput("pre_rst_w_valid", bus.w_valid_o, 1'b1);
                rst = 1'b1;
                #1;
                checkOutput("rst_w_valid", bus.w_valid_o, 1'b0);
                checkOutput("rst_in_ready", bus.in_ready_o, 1'b0);
                checkOutput("rst_meta_ready", bus.meta_ready_o, 1'b0);
                checkOutput("rst_aw_valid", bus.aw_valid_o, 1'b0);
                checkOutput("rst_b_ready", bus.b_ready_o, 1'b0);
                checkOutput("rst_done", bus.done_o, 1'b0);
                checkOutput("rst_w_data", bus.w_data_o, '0);
                expQ.delete();
                bus.in_valid_i = 1'b0;
                bus.w_ready_i  = 1'b0;
                nextCycle();
                nextCycle();
                rst = 1'b0;
                @(negedge clk);
                checkOutput("post_rst_done", bus.done_o, 1'b0);
                checkOutput("post_rst_meta_ready", bus.meta_ready_o, 1'b1);
                return;
            end

            bus.w_ready_i = 1'b0;
            for (int s = 0; s < stallCycles && j == stallBeat; s++) begin
                @(negedge clk);
                mask = '0;
                for (int k = 0; k < BusBytes; k++) mask[8*k +: 8] = {8{expQ[0].strb[k]}};
                checkOutput("stall_in_ready", bus.in_ready_o, 1'b0);
                checkOutput("stall_w_valid", bus.w_valid_o, 1'b1);
                checkOutput("stall_w_data", bus.w_data_o & mask, expQ[0].data & mask);
                nextCycle();
            end

            bus.w_ready_i = 1'b1;
            @(negedge clk);
            if (j >= nbeats) checkOutput("flush_in_ready", bus.in_ready_o, 1'b0);
            checkOutput("w_valid", bus.w_valid_o, 1'b1);
            e = expQ.pop_front();
            mask = '0;
            for (int k = 0; k < BusBytes; k++) mask[8*k +: 8] = {8{e.strb[k]}};
            checkOutput("w_strb", bus.w_strb_o, e.strb);
            checkOutput("w_data", bus.w_data_o & mask, e.data & mask);
            checkOutput("w_last", bus.w_last_o, e.last);
            nextCycle();
        end

        bus.in_valid_i = 1'b0;
        bus.w_ready_i  = 1'b0;
        @(negedge clk);
        checkOutput("resp_b_ready", bus.b_ready_o, 1'b1);
        checkOutput("resp_w_valid", bus.w_valid_o, 1'b0);
        checkOutput("done_early", bus.done_o, 1'b0);
        checkOutput("sb_empty", expQ.size(), 0);
        nextCycle();
        bus.b_valid_i = 1'b1;
        bus.b_err_i   = berr;
        @(negedge clk);
        checkOutput("done", bus.done_o, 1'b1);
        checkOutput("done_reqid", bus.done_reqid_o, reqid);
        checkOutput("done_err", bus.done_err_o, expErr);
        nextCycle();
        bus.b_valid_i = 1'b0;
        bus.b_err_i   = 1'b0;
        @(negedge clk);
        checkOutput("done_pulse", bus.done_o, 1'b0);
        checkOutput("meta_ready_after", bus.meta_ready_o, 1'b1);
    endtask

    initial begin
        bus.meta_valid_i  = 1'b0;
        bus.meta_addr_i   = '0;
        bus.meta_nbeats_i = '0;
        bus.meta_reqid_i  = '0;
        bus.in_valid_i    = 1'b0;
        bus.in_nb_i       = '0;
        bus.in_en_i       = '0;
        bus.aw_ready_i    = 1'b0;
        bus.w_ready_i     = 1'b0;
        bus.b_valid_i     = 1'b0;
        bus.b_err_i       = 1'b0;

        @(negedge clk);
        checkOutput("reset_meta_ready", bus.meta_ready_o, 1'b0);
        checkOutput("reset_aw_valid", bus.aw_valid_o, 1'b0);
        checkOutput("reset_w_valid", bus.w_valid_o, 1'b0);
        checkOutput("reset_in_ready", bus.in_ready_o, 1'b0);
        checkOutput("reset_b_ready", bus.b_ready_o, 1'b0);
        checkOutput("reset_done", bus.done_o, 1'b0);
        checkOutput("reset_aw_len", bus.aw_len_o, '0);
        checkOutput("reset_w_data", bus.w_data_o, '0);
        nextCycle();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle_meta_ready", bus.meta_ready_o, 1'b1);

        $display("[TB] aligned two-beat burst");
        applyStimulus(64'h1000, 2, 4'h3, 1'b0, -1, 0, -1, 0);
        $display("[TB] misaligned burst with flush, stalled second beat");
        applyStimulus(64'h1004, 2, 4'h5, 1'b0, 1, 3, -1, 0);
        $display("[TB] nibble enable mismatch");
        applyStimulus(64'h2000, 1, 4'h7, 1'b0, -1, 0, 0, 0);
        applyStimulus(64'h2010, 3, 4'h8, 1'b0, -1, 0, -1, 0);
        $display("[TB] error response then back-to-back request");
        applyStimulus(64'h3000, 2, 4'h9, 1'b1, -1, 0, -1, 0);
        applyStimulus(64'h301F, 1, 4'hA, 1'b0, -1, 0, -1, 0);
        $display("[TB] reset during data phase");
        applyStimulus(64'h4000, 4, 4'hB, 1'b0, -1, 0, -1, 2);
        applyStimulus(64'h1000, 2, 4'h3, 1'b0, -1, 0, -1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, failCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no end of test, expected finish before timeout");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
